// File: rtl/simon_block_seq.sv
// simon_block_seq
//   Block-level sequencer in front of a SimonCore configured for Simon 64/128.
//   Owns the key-load handshake, accepts one 64-bit block {x,y} from the host,
//   steps the core one round at a time (core_r_single=1) for ROUNDS rounds and
//   returns the finished block {x,y} over a valid/ready port.
//
//   Optional feature macro: SIMON_SEQ_TIMEOUT_EN
//     defined   : 8-bit per-round watchdog in WAIT; on expiry sets sticky err,
//                 drops the block and returns to IDLE.
//     undefined : WAIT waits indefinitely, err tied to 0.
//
// Ports
//   clk, nrst            clock, synchronous active-low reset
//   key/key_load         128-bit key, load request (NOKEY/IDLE only)
//   key_ready            expanded key valid
//   blk_in*              host input block, encrypt/decrypt select, valid/ready
//   blk_out*             result block, valid/ready
//   busy                 key expansion or block in progress
//   err                  sticky round-timeout flag
//   core_*               SimonCore handshake, key and data signals
module simon_block_seq #(
    parameter int ROUNDS = 44,
    parameter int CNT_W  = 6
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [127:0]  key,
    input  logic          key_load,
    output logic          key_ready,
    input  logic [63:0]   blk_in,
    input  logic          blk_in_enc,
    input  logic          blk_in_valid,
    output logic          blk_in_ready,
    output logic [63:0]   blk_out,
    output logic          blk_out_valid,
    input  logic          blk_out_ready,
    output logic          busy,
    output logic          err,
    output logic [63:0]   core_key_l,
    output logic [63:0]   core_key_h,
    output logic          core_k_valid,
    input  logic          core_k_exp_done,
    output logic          core_s_mode,
    output logic [63:0]   core_data1_in,
    output logic [63:0]   core_data2_in,
    input  logic [63:0]   core_data1_out,
    input  logic [63:0]   core_data2_out,
    input  logic          core_d_in_ready,
    output logic          core_d_in_valid,
    input  logic          core_d_out_valid,
    output logic          core_d_enc_dec,
    output logic          core_r_single
);

    localparam logic SIMON_MODE_64_128 = 1'b0;

    localparam logic [2:0] NOKEY = 3'd0;
    localparam logic [2:0] KREQ  = 3'd1;
    localparam logic [2:0] KWAIT = 3'd2;
    localparam logic [2:0] IDLE  = 3'd3;
    localparam logic [2:0] ISSUE = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [127:0]     key_q, key_d;
    logic             key_ready_q, key_ready_d;
    logic [63:0]      data1_q, data1_d;
    logic [63:0]      data2_q, data2_d;
    logic             enc_q, enc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SIMON_SEQ_TIMEOUT_EN
    logic [7:0]       wdog_q, wdog_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_ready_d = key_ready_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        enc_d       = enc_q;
        cnt_d       = cnt_q;
`ifdef SIMON_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        case (state_q)
            NOKEY: begin
                if (key_load) begin
                    key_d       = key;
                    key_ready_d = 1'b0;
                    state_d     = KREQ;
                end
            end
            KREQ: state_d = KWAIT;
            KWAIT: begin
                if (core_k_exp_done) begin
                    key_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                // key_load has priority over a pending block
                if (key_load) begin
                    key_d       = key;
                    key_ready_d = 1'b0;
                    state_d     = KREQ;
                end else if (blk_in_valid) begin
                    data1_d = {32'b0, blk_in[31:0]};
                    data2_d = {32'b0, blk_in[63:32]};
                    enc_d   = blk_in_enc;
                    cnt_d   = CNT_W'(ROUNDS);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_d_in_ready) begin
                    state_d = WAIT;
`ifdef SIMON_SEQ_TIMEOUT_EN
                    wdog_d  = 8'd0;
`endif
                end
            end
            WAIT: begin
                if (core_d_out_valid) begin
                    data1_d = core_data1_out;
                    data2_d = core_data2_out;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : ISSUE;
                end
`ifdef SIMON_SEQ_TIMEOUT_EN
                else begin
                    wdog_d = wdog_q + 8'd1;
                    // counter is about to reach 255: give up on this block
                    if (wdog_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
            end
            DONE: begin
                if (blk_out_ready) state_d = IDLE;
            end
            default: state_d = NOKEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= NOKEY;
            key_q       <= '0;
            key_ready_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            enc_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef SIMON_SEQ_TIMEOUT_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_ready_q <= key_ready_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            enc_q       <= enc_d;
            cnt_q       <= cnt_d;
`ifdef SIMON_SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    assign key_ready       = key_ready_q;
    assign blk_in_ready    = (state_q == IDLE) && !key_load;
    assign blk_out         = {data2_q[31:0], data1_q[31:0]};
    assign blk_out_valid   = (state_q == DONE);
    assign busy            = !((state_q == NOKEY) || (state_q == IDLE) || (state_q == DONE));
`ifdef SIMON_SEQ_TIMEOUT_EN
    assign err             = err_q;
`else
    assign err             = 1'b0;
`endif
    assign core_key_l      = key_q[63:0];
    assign core_key_h      = key_q[127:64];
    assign core_k_valid    = (state_q == KREQ);
    assign core_s_mode     = SIMON_MODE_64_128;
    assign core_data1_in   = data1_q;
    assign core_data2_in   = data2_q;
    assign core_d_in_valid = (state_q == ISSUE);
    assign core_d_enc_dec  = enc_q;
    assign core_r_single   = 1'b1;

endmodule
